// File: rtl/main_mem_ctrl_if.sv
// main_mem_ctrl_if: request/response bundle between the cache controller
// (master) and the main memory controller (slave).
interface main_mem_ctrl_if;
    logic [29:0] addr;
    logic        mem_read_ce;
    logic        mem_write_ce;
    logic [31:0] wb_data;
    logic [31:0] mem_data;
    logic        mem_read_fin;
    logic        mem_write_fin;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output addr, mem_read_ce, mem_write_ce, wb_data,
        input  mem_data, mem_read_fin, mem_write_fin, rd_count, wr_count
    );

    modport slave (
        input  addr, mem_read_ce, mem_write_ce, wb_data,
        output mem_data, mem_read_fin, mem_write_fin, rd_count, wr_count
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: fixed-latency 32-bit word memory behind the cache.
// One request at a time: accept in IDLE, wait LATENCY cycles in BUSY,
// complete on entry to DONE (array write or mem_data load), pulse fin
// for one cycle, return to IDLE. Writes win over simultaneous reads.
// Optional feature macro: MAIN_MEM_STATS_EN enables the rd_count/wr_count
// completion counters; without it both outputs are tied to zero.
module main_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input logic             clk,
    input logic             rst,
    main_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAT_CNT = 8'(LATENCY);
    // With a one-cycle latency the acceptance edge is also the completion edge.
    localparam bit         DIRECT  = (LATENCY == 1);

    state_t              state, state_nx;
    logic [7:0]          cnt;
    logic                op_wr;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         data_q;
    logic [31:0]         mem_data_q;
    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                complete;
    logic                cmp_wr;
    logic [ADDR_W-1:0]   cmp_idx;
    logic [31:0]         cmp_data;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^bus.addr[29:ADDR_W];

    // Next state, acceptance/completion strobes and the completion operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nx = state;
        accept   = 1'b0;
        complete = 1'b0;
        cmp_wr   = op_wr;
        cmp_idx  = idx_q;
        cmp_data = data_q;
        case (state)
            IDLE: begin
                if (bus.mem_write_ce || bus.mem_read_ce) begin
                    accept   = 1'b1;
                    complete = DIRECT;
                    cmp_wr   = bus.mem_write_ce;
                    cmp_idx  = bus.addr[ADDR_W-1:0];
                    cmp_data = bus.wb_data;
                    state_nx = DIRECT ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    complete = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, latency counter, captured request and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            op_wr      <= 1'b0;
            idx_q      <= '0;
            data_q     <= 32'd0;
            mem_data_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt    <= complete ? 8'd0 : LAT_CNT;
                op_wr  <= cmp_wr;
                idx_q  <= cmp_idx;
                data_q <= cmp_data;
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            if (complete && !cmp_wr) begin
                mem_data_q <= mem[cmp_idx];
            end
        end
    end

    // Backing array write at the completion edge of a write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing 2^ADDR_W words would force it out of RAM macros.
        if (complete && cmp_wr) begin
            mem[cmp_idx] <= cmp_data;
        end
    end

    assign bus.mem_data      = mem_data_q;
    assign bus.mem_write_fin = (state == DONE) &&  op_wr;
    assign bus.mem_read_fin  = (state == DONE) && !op_wr;

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;

    // Completion counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (complete) begin
            if (cmp_wr) wr_cnt <= wr_cnt + 16'd1;
            else        rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign bus.rd_count = rd_cnt;
    assign bus.wr_count = wr_cnt;
`else
    assign bus.rd_count = 16'd0;
    assign bus.wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: directed vectors for main_mem_ctrl. Drivers push the
// expected completion (kind, cycle, read data) into a scoreboard queue;
// per-DUT monitors pop and compare whenever a fin pulse appears.
// Two instances: LATENCY=4 (main checks) and LATENCY=1.
module tb_main_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    main_mem_ctrl_if bus4();
    main_mem_ctrl_if bus1();

    main_mem_ctrl #(.ADDR_W(10), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    main_mem_ctrl #(.ADDR_W(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sb4[$];
    exp_t sb1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus4.mem_write_fin || bus4.mem_read_fin) begin
                check("l4_fin_exclusive", 32'(bus4.mem_write_fin & bus4.mem_read_fin), 32'd0);
                if (sb4.size() == 0) begin
                    check("l4_unexpected_fin", 32'd1, 32'd0);
                end else begin
                    e = sb4.pop_front();
                    check({e.name, "_kind_wr"}, 32'(bus4.mem_write_fin), 32'(e.is_wr));
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                    if (!e.is_wr) check({e.name, "_data"}, bus4.mem_data, e.data);
                end
            end else if (sb4.size() > 0 && cyc > sb4[0].due) begin
                e = sb4.pop_front();
                check({e.name, "_missing_fin"}, 32'd0, 32'd1);
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus1.mem_write_fin || bus1.mem_read_fin) begin
                check("l1_fin_exclusive", 32'(bus1.mem_write_fin & bus1.mem_read_fin), 32'd0);
                if (sb1.size() == 0) begin
                    check("l1_unexpected_fin", 32'd1, 32'd0);
                end else begin
                    e = sb1.pop_front();
                    check({e.name, "_kind_wr"}, 32'(bus1.mem_write_fin), 32'(e.is_wr));
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                    if (!e.is_wr) check({e.name, "_data"}, bus1.mem_data, e.data);
                end
            end else if (sb1.size() > 0 && cyc > sb1[0].due) begin
                e = sb1.pop_front();
                check({e.name, "_missing_fin"}, 32'd0, 32'd1);
            end
        end
    end

    // One request on the LATENCY=4 instance; ce held until its fin is seen.
    task automatic op4(input bit wr, input bit rd, input logic [29:0] a,
                       input logic [31:0] d, input logic [31:0] rd_exp, input string name);
        int base;
        int n;
        @(negedge clk);
        bus4.addr         = a;
        bus4.wb_data      = d;
        bus4.mem_write_ce = wr;
        bus4.mem_read_ce  = rd;
        base = cyc + 1;
        if (wr) sb4.push_back('{1'b1, 32'd0, base + 4, {name, "_wr"}});
        // A deferred read waits for DONE->IDLE plus one idle edge after the write.
        if (rd) sb4.push_back('{1'b0, rd_exp, wr ? base + 10 : base + 4, {name, "_rd"}});
        n = 0;
        while ((bus4.mem_write_ce || bus4.mem_read_ce) && n < 100) begin
            @(negedge clk);
            n++;
            if (bus4.mem_write_fin) bus4.mem_write_ce = 1'b0;
            if (bus4.mem_read_fin)  bus4.mem_read_ce  = 1'b0;
        end
        if (n >= 100) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            bus4.mem_write_ce = 1'b0;
            bus4.mem_read_ce  = 1'b0;
        end
    endtask

    // One request on the LATENCY=1 instance: DONE is entered at the acceptance edge.
    task automatic op1(input bit wr, input bit rd, input logic [29:0] a,
                       input logic [31:0] d, input logic [31:0] rd_exp, input string name);
        int base;
        int n;
        @(negedge clk);
        bus1.addr         = a;
        bus1.wb_data      = d;
        bus1.mem_write_ce = wr;
        bus1.mem_read_ce  = rd;
        base = cyc + 1;
        if (wr) sb1.push_back('{1'b1, 32'd0, base, {name, "_wr"}});
        if (rd) sb1.push_back('{1'b0, rd_exp, wr ? base + 2 : base, {name, "_rd"}});
        n = 0;
        while ((bus1.mem_write_ce || bus1.mem_read_ce) && n < 100) begin
            @(negedge clk);
            n++;
            if (bus1.mem_write_fin) bus1.mem_write_ce = 1'b0;
            if (bus1.mem_read_fin)  bus1.mem_read_ce  = 1'b0;
        end
        if (n >= 100) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            bus1.mem_write_ce = 1'b0;
            bus1.mem_read_ce  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_data"},  bus4.mem_data, 32'd0);
        check({tag, "_write_fin"}, 32'(bus4.mem_write_fin), 32'd0);
        check({tag, "_read_fin"},  32'(bus4.mem_read_fin), 32'd0);
        check({tag, "_rd_count"},  32'(bus4.rd_count), 32'd0);
        check({tag, "_wr_count"},  32'(bus4.wr_count), 32'd0);
        check({tag, "_l1_mem_data"}, bus1.mem_data, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus4.addr = '0; bus4.wb_data = '0; bus4.mem_read_ce = 1'b0; bus4.mem_write_ce = 1'b0;
        bus1.addr = '0; bus1.wb_data = '0; bus1.mem_read_ce = 1'b0; bus1.mem_write_ce = 1'b0;
        #1;
        check_reset_outputs("reset_init");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;

        // Basic write, then read back with hold check.
        op4(1'b1, 1'b0, 30'h005, 32'hDEADBEEF, 32'h0, "wr_005");
        op4(1'b0, 1'b1, 30'h005, 32'h0, 32'hDEADBEEF, "rd_005");
        repeat (3) @(negedge clk);
        check("rd_005_hold", bus4.mem_data, 32'hDEADBEEF);

        // Simultaneous read and write: write first, then the still-held read.
        op4(1'b1, 1'b1, 30'h010, 32'h12345678, 32'h12345678, "both_010");

        // Upper address bits alias.
        op4(1'b1, 1'b0, 30'h3FFF_F405, 32'hA5A5A5A5, 32'h0, "wr_alias");
        op4(1'b0, 1'b1, 30'h005, 32'h0, 32'hA5A5A5A5, "rd_alias");

        // Reset aborts a write in flight; prior array contents survive.
        op4(1'b1, 1'b0, 30'h020, 32'h22222222, 32'h0, "wr_020");
        @(negedge clk);
        bus4.addr         = 30'h020;
        bus4.wb_data      = 32'h11111111;
        bus4.mem_write_ce = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_abort");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_abort_held");
        bus4.mem_write_ce = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_mem_data", bus4.mem_data, 32'd0);
        op4(1'b0, 1'b1, 30'h020, 32'h0, 32'h22222222, "rd_020");

        // Three writes and a second read since the last reset.
        op4(1'b1, 1'b0, 30'h030, 32'h00000001, 32'h0, "wr_030");
        op4(1'b1, 1'b0, 30'h031, 32'h00000002, 32'h0, "wr_031");
        op4(1'b1, 1'b0, 30'h032, 32'h00000003, 32'h0, "wr_032");
        op4(1'b0, 1'b1, 30'h031, 32'h0, 32'h00000002, "rd_031");
        @(negedge clk);
`ifdef MAIN_MEM_STATS_EN
        check("wr_count", 32'(bus4.wr_count), 32'd3);
        check("rd_count", 32'(bus4.rd_count), 32'd2);
`else
        check("wr_count", 32'(bus4.wr_count), 32'd0);
        check("rd_count", 32'(bus4.rd_count), 32'd0);
`endif

        // LATENCY=1 instance.
        op1(1'b1, 1'b0, 30'h003, 32'hCAFEF00D, 32'h0, "l1_wr_003");
        op1(1'b0, 1'b1, 30'h003, 32'h0, 32'hCAFEF00D, "l1_rd_003");
        op1(1'b1, 1'b1, 30'h007, 32'h0BADF00D, 32'h0BADF00D, "l1_both_007");

        n = 0;
        while ((sb4.size() > 0 || sb1.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb4.size() + sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, number of low word-address bits indexing the backing array (2^ADDR_W words of 32 bits) SHALL be supported.
REQ-002 Parameter LATENCY, default 4, cycles from request acceptance to completion pulse; legal range 1..255 SHALL be supported.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 addr  in  30  word address from the cache controller; only addr[ADDR_W-1:0] used.
REQ-006 mem_read_ce  in  1  read request level, held until mem_read_fin seen.
REQ-007 mem_write_ce  in  1  write-back request level, held until mem_write_fin seen.
REQ-008 wb_data  in  32  write-back data from the cache.
REQ-009 mem_data  out  32  registered read data.
REQ-010 mem_read_fin  out  1  one-cycle read completion pulse.
REQ-011 mem_write_fin  out  1  one-cycle write completion pulse.
REQ-012 rd_count  out  16  completed-read counter (see Configuration).
REQ-013 wr_count  out  16  completed-write counter (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; encoding free.
REQ-015 IDLE: at an edge with mem_write_ce=1 the block SHALL accept a write, capture addr index and wb_data, load latency counter, go to BUSY (or DONE directly if LATENCY=1).
REQ-016 IDLE: at an edge with mem_read_ce=1 and mem_write_ce=0 the block SHALL accept a read, capture addr index, go to BUSY (or DONE if LATENCY=1).
REQ-017 Simultaneous mem_read_ce and mem_write_ce in IDLE SHALL be served as write first; the read is accepted later only if still requested.
REQ-018 BUSY: counter SHALL decrement each cycle; on the edge where it would reach zero, state SHALL go to DONE.
REQ-019 Completion edge (entry to DONE) SHALL: for write, store captured data into array at captured index; for read, load mem_data from array at captured index.
REQ-020 DONE SHALL last exactly one cycle with the matching fin output high; the other fin output SHALL stay 0.
REQ-021 Fin pulse SHALL therefore be high in the cycle beginning LATENCY edges after the acceptance edge.
REQ-022 DONE SHALL return to IDLE unconditionally; ce inputs are ignored at the DONE->IDLE edge, so earliest next acceptance is the edge after.
REQ-023 mem_data SHALL be valid throughout the mem_read_fin cycle and hold until the next read completion.
REQ-024 Changes of addr/wb_data/ce during BUSY SHALL have no effect on the operation in flight.
REQ-025 addr bits above ADDR_W-1 SHALL be ignored (aliasing, no error).

Reset
REQ-026 On rst: state IDLE, mem_data=0, mem_read_fin=0, mem_write_fin=0, counter=0, rd_count=0, wr_count=0.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 rst asserted during BUSY SHALL abort the operation: no array write, no fin pulse, mem_data stays 0.

Configuration
REQ-029 Macro MAIN_MEM_STATS_EN defined: rd_count/wr_count SHALL increment by 1 at each read/write completion edge, wrapping 0xFFFF->0x0000.
REQ-030 MAIN_MEM_STATS_EN undefined: rd_count and wr_count SHALL be constant 0 and no counter registers exist.

Verification
REQ-031 LATENCY=4: write_ce with addr=0x005, wb_data=0xDEADBEEF at edge E0 -> mem_write_fin high only in cycle after E4, low otherwise.
REQ-032 Following write, read_ce addr=0x005 -> mem_read_fin pulse 4 cycles after acceptance with mem_data=0xDEADBEEF, held after pulse.
REQ-033 read_ce and write_ce both high in IDLE, addr=0x010, wb_data=0x12345678 -> write_fin first; read then accepted and returns 0x12345678.
REQ-034 addr=0x3FFF_F405 written 0xA5A5A5A5 (ADDR_W=10) -> read of addr=0x005 returns 0xA5A5A5A5.
REQ-035 rst asserted 2 cycles into write of 0x11111111 to addr 0x020 holding prior 0x22222222 -> no fin, later read returns 0x22222222, all outputs 0 during reset.
REQ-036 MAIN_MEM_STATS_EN defined, 3 writes + 2 reads -> wr_count=3, rd_count=2; undefined -> both 0; LATENCY=1 -> fin in cycle right after acceptance edge.
